// File: rtl/acl2_spi_responder.sv
// acl2_spi_responder: SPI mode-0 responder modelled on the ADXL362-style
// command set (0x0A write, 0x0B read). SCLK/MOSI/CS are oversampled on the
// system clock. The register map holds ID bytes, three axis samples and a
// 16-byte read/write block (0x20-0x2F, POWER_CTL at 0x2D).
// Optional feature: define ACL2_RESP_SIGNEXT_EN to sign-extend the upper
// nibble of the axis high-byte registers; otherwise that nibble reads 0000.
// o_dbg_state exposes the transaction FSM state for observation.
module acl2_spi_responder #(
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] PART_ID     = 8'hF2
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_sclk,
    input  logic        i_mosi,
    input  logic        i_cs_n,
    output logic        o_miso,
    input  logic        i_sample_load,
    input  logic [11:0] i_sample_x,
    input  logic [11:0] i_sample_y,
    input  logic [11:0] i_sample_z,
    output logic        o_wr_strobe,
    output logic [5:0]  o_wr_addr,
    output logic [7:0]  o_wr_data,
    output logic        o_measure_on,
    output logic        o_busy,
    output logic [2:0]  o_dbg_state
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_INS    = 3'd1,
        ST_ADDR   = 3'd2,
        ST_DATA   = 3'd3,
        ST_IGNORE = 3'd4
    } state_t;

    localparam logic [1:0] LP_FLUSH = 2'(SYNC_STAGES);

    logic [SYNC_STAGES-1:0] r_sclk_sync, r_mosi_sync, r_cs_sync;
    logic                   r_sclk_d, r_cs_d, r_armed;
    logic [1:0]             r_flush_cnt;
    logic [11:0]            r_data_x, r_data_y, r_data_z;
    logic [11:0]            r_snap_x, r_snap_y, r_snap_z;
    logic [7:0]             r_rw [16];
    state_t                 r_state;
    logic [2:0]             r_bit_cnt;
    logic [6:0]             r_rx;
    logic                   r_is_rd, r_load_pend, r_miso, r_wr_strobe;
    logic [5:0]             r_addr, r_wr_addr;
    logic [7:0]             r_tx, r_wr_data, w_rd_data, w_byte;
    logic                   w_sclk, w_mosi, w_cs;
    logic                   w_sclk_rise, w_sclk_fall, w_cs_fall, w_cs_rise, w_byte_done;

    // High byte of an axis register: sample[11:8] plus the configured upper nibble.
    function automatic logic [7:0] f_hi(input logic [11:0] s);
`ifdef ACL2_RESP_SIGNEXT_EN
        return {{4{s[11]}}, s[11:8]};
`else
        return {4'b0000, s[11:8]};
`endif
    endfunction

    assign w_sclk = r_sclk_sync[SYNC_STAGES-1];
    assign w_mosi = r_mosi_sync[SYNC_STAGES-1];
    assign w_cs   = r_cs_sync[SYNC_STAGES-1];

    assign w_sclk_rise = ~r_sclk_d & w_sclk;
    assign w_sclk_fall = r_sclk_d & ~w_sclk;
    // A falling CS only counts once the bus has been seen idle after reset,
    // so a CS already low at reset release cannot start a transaction.
    assign w_cs_fall   = r_armed & r_cs_d & ~w_cs;
    assign w_cs_rise   = ~r_cs_d & w_cs;
    assign w_byte      = {r_rx, w_mosi};
    assign w_byte_done = w_sclk_rise && (r_bit_cnt == 3'd7);

    assign o_miso       = r_miso;
    assign o_wr_strobe  = r_wr_strobe;
    assign o_wr_addr    = r_wr_addr;
    assign o_wr_data    = r_wr_data;
    assign o_measure_on = (r_rw[13][1:0] == 2'b10);
    assign o_busy       = ~w_cs;
    assign o_dbg_state  = r_state;

    // Input synchronizers, reset to the idle bus level.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sclk_sync <= '0;
            r_mosi_sync <= '0;
            r_cs_sync   <= '1;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_sclk};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], i_mosi};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], i_cs_n};
        end
    end

    // Edge-detect history and arming once the synchronizers hold real bus values.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_sclk_d    <= 1'b0;
            r_cs_d      <= 1'b1;
            r_armed     <= 1'b0;
            r_flush_cnt <= 2'd0;
        end else begin
            r_sclk_d <= w_sclk;
            r_cs_d   <= w_cs;
            if (r_flush_cnt != LP_FLUSH)
                r_flush_cnt <= r_flush_cnt + 2'd1;
            else if (w_cs)
                r_armed <= 1'b1;
        end
    end

    // Live axis data registers, loaded by the sample strobe.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_data_x <= '0;
            r_data_y <= '0;
            r_data_z <= '0;
        end else if (i_sample_load) begin
            r_data_x <= i_sample_x;
            r_data_y <= i_sample_y;
            r_data_z <= i_sample_z;
        end
    end

    // Read mux over the register map; axis bytes come from the snapshot.
    always_comb begin
        w_rd_data = 8'h00;
        if (r_addr[5:4] == 2'b10) begin
            w_rd_data = r_rw[r_addr[3:0]];
        end else begin
            case (r_addr)
                6'h00:   w_rd_data = 8'hAD;
                6'h01:   w_rd_data = 8'h1D;
                6'h02:   w_rd_data = PART_ID;
                6'h0E:   w_rd_data = r_snap_x[7:0];
                6'h0F:   w_rd_data = f_hi(r_snap_x);
                6'h10:   w_rd_data = r_snap_y[7:0];
                6'h11:   w_rd_data = f_hi(r_snap_y);
                6'h12:   w_rd_data = r_snap_z[7:0];
                6'h13:   w_rd_data = f_hi(r_snap_z);
                default: w_rd_data = 8'h00;
            endcase
        end
    end

    // Transaction FSM: byte assembly, address tracking, writes and MISO shifting.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= ST_IDLE;
            r_bit_cnt   <= 3'd0;
            r_rx        <= '0;
            r_is_rd     <= 1'b0;
            r_load_pend <= 1'b0;
            r_addr      <= '0;
            r_tx        <= '0;
            r_miso      <= 1'b0;
            r_wr_strobe <= 1'b0;
            r_wr_addr   <= '0;
            r_wr_data   <= '0;
            r_snap_x    <= '0;
            r_snap_y    <= '0;
            r_snap_z    <= '0;
            for (int i = 0; i < 16; i++) r_rw[i] <= 8'h00;
        end else begin
            r_wr_strobe <= 1'b0;
            if (w_cs_rise) begin
                // Any partial byte is simply dropped here.
                r_state     <= ST_IDLE;
                r_bit_cnt   <= 3'd0;
                r_load_pend <= 1'b0;
                r_miso      <= 1'b0;
            end else if (r_state == ST_IDLE) begin
                if (w_cs_fall) begin
                    r_state     <= ST_INS;
                    r_bit_cnt   <= 3'd0;
                    r_load_pend <= 1'b0;
                    r_miso      <= 1'b0;
                    r_snap_x    <= r_data_x;
                    r_snap_y    <= r_data_y;
                    r_snap_z    <= r_data_z;
                end
            end else begin
                if (w_sclk_rise) begin
                    r_rx      <= w_byte[6:0];
                    r_bit_cnt <= r_bit_cnt + 3'd1;
                end
                if (w_byte_done) begin
                    case (r_state)
                        ST_INS: begin
                            if (w_byte == 8'h0A) begin
                                r_is_rd <= 1'b0;
                                r_state <= ST_ADDR;
                            end else if (w_byte == 8'h0B) begin
                                r_is_rd <= 1'b1;
                                r_state <= ST_ADDR;
                            end else begin
                                r_state <= ST_IGNORE;
                            end
                        end
                        ST_ADDR: begin
                            r_addr      <= w_byte[5:0];
                            r_state     <= ST_DATA;
                            r_load_pend <= r_is_rd;
                        end
                        ST_DATA: begin
                            if (r_is_rd) begin
                                r_load_pend <= 1'b1;
                            end else begin
                                r_wr_strobe <= 1'b1;
                                r_wr_addr   <= r_addr;
                                r_wr_data   <= w_byte;
                                if (r_addr[5:4] == 2'b10) r_rw[r_addr[3:0]] <= w_byte;
                            end
                            r_addr <= r_addr + 6'd1;
                        end
                        default: ;
                    endcase
                end
                if (w_sclk_fall && (r_state == ST_DATA) && r_is_rd) begin
                    if (r_load_pend) begin
                        r_tx        <= w_rd_data;
                        r_miso      <= w_rd_data[7];
                        r_load_pend <= 1'b0;
                    end else begin
                        r_tx   <= {r_tx[6:0], 1'b0};
                        r_miso <= r_tx[6];
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_acl2_spi_responder.sv
// Bench for acl2_spi_responder: table of SPI transactions with hand-computed
// read data and write strobes, plus sequences for snapshot coherence,
// aborted bytes and reset mid-burst.
`timescale 1ns/1ps
module tb_acl2_spi_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sclk = 1'b0, mosi = 1'b0, cs_n = 1'b1, sample_load = 1'b0;
    logic [11:0] sx = '0, sy = '0, sz = '0;
    logic        miso, wr_strobe, measure_on, busy;
    logic [5:0]  wr_addr;
    logic [7:0]  wr_data;
    logic [2:0]  dbg_state;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [13:0] act_q[$];
    logic [13:0] exp_q[$];

`ifdef ACL2_RESP_SIGNEXT_EN
    localparam logic [7:0] XH = 8'hFF;
    localparam logic [7:0] ZH = 8'hF9;
`else
    localparam logic [7:0] XH = 8'h0F;
    localparam logic [7:0] ZH = 8'h09;
`endif

    typedef struct {
        logic [7:0]  ins;
        logic [7:0]  addr;
        int          n;
        logic [47:0] bytes;
        logic        exp_meas;
    } vec_t;

    vec_t vecs[14];

    always #5 clk = ~clk;

    acl2_spi_responder dut (
        .i_clk(clk), .i_rst(rst), .i_sclk(sclk), .i_mosi(mosi), .i_cs_n(cs_n),
        .o_miso(miso), .i_sample_load(sample_load),
        .i_sample_x(sx), .i_sample_y(sy), .i_sample_z(sz),
        .o_wr_strobe(wr_strobe), .o_wr_addr(wr_addr), .o_wr_data(wr_data),
        .o_measure_on(measure_on), .o_busy(busy), .o_dbg_state(dbg_state)
    );

    // Record every write strobe seen.
    always @(negedge clk) if (wr_strobe) act_q.push_back({wr_addr, wr_data});

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic spi_bits(input logic [7:0] tx, input int nb, output logic [7:0] rx);
        rx = 8'h00;
        for (int i = 0; i < nb; i++) begin
            mosi = tx[7-i];
            wait_clk(8);
            rx[7-i] = miso;
            sclk = 1'b1;
            wait_clk(8);
            sclk = 1'b0;
        end
    endtask

    task automatic cs_start();
        cs_n = 1'b0;
        wait_clk(8);
    endtask

    task automatic cs_stop();
        wait_clk(8);
        cs_n = 1'b1;
        mosi = 1'b0;
        wait_clk(8);
    endtask

    task automatic pulse_load(input logic [11:0] x, input logic [11:0] y, input logic [11:0] z);
        sx = x; sy = y; sz = z;
        sample_load = 1'b1;
        wait_clk(1);
        sample_load = 1'b0;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        logic [7:0] rx, b;
        logic [5:0] a;
        logic       is_rd, is_wr;
        is_rd = (v.ins == 8'h0B);
        is_wr = (v.ins == 8'h0A);
        act_q.delete();
        exp_q.delete();
        cs_start();
        spi_bits(v.ins, 8, rx);
        check($sformatf("v%0d ins_miso", idx), 64'(rx), 64'h0);
        spi_bits(v.addr, 8, rx);
        check($sformatf("v%0d addr_miso", idx), 64'(rx), 64'h0);
        for (int k = 0; k < v.n; k++) begin
            b = v.bytes[47-8*k -: 8];
            spi_bits(is_rd ? 8'h00 : b, 8, rx);
            check($sformatf("v%0d byte%0d", idx, k), 64'(rx), is_rd ? 64'(b) : 64'h0);
            if (is_wr) begin
                a = v.addr[5:0] + 6'(k);
                exp_q.push_back({a, b});
            end
        end
        cs_stop();
        check($sformatf("v%0d strobe_count", idx), 64'(act_q.size()), 64'(exp_q.size()));
        for (int j = 0; j < exp_q.size() && j < act_q.size(); j++)
            check($sformatf("v%0d strobe%0d", idx, j), 64'(act_q[j]), 64'(exp_q[j]));
        check($sformatf("v%0d measure_on", idx), 64'(measure_on), 64'(v.exp_meas));
    endtask

    initial begin : main
        logic [7:0] rx;
        vec_t       hv;

        vecs[0]  = '{8'h0B, 8'h00, 3, {8'hAD, 8'h1D, 8'hF2, 24'h0}, 1'b0};
        vecs[1]  = '{8'h0A, 8'h2D, 1, {8'h02, 40'h0}, 1'b1};
        vecs[2]  = '{8'h0B, 8'h2D, 1, {8'h02, 40'h0}, 1'b1};
        vecs[3]  = '{8'h0A, 8'h3F, 2, {8'h11, 8'h22, 32'h0}, 1'b1};
        vecs[4]  = '{8'h0B, 8'h00, 1, {8'hAD, 40'h0}, 1'b1};
        vecs[5]  = '{8'h0B, 8'hC2, 1, {8'hF2, 40'h0}, 1'b1};
        vecs[6]  = '{8'h0A, 8'h20, 2, {8'hA5, 8'h5A, 32'h0}, 1'b1};
        vecs[7]  = '{8'h0B, 8'h20, 2, {8'hA5, 8'h5A, 32'h0}, 1'b1};
        vecs[8]  = '{8'h0B, 8'h3F, 2, {8'h00, 8'hAD, 32'h0}, 1'b1};
        vecs[9]  = '{8'h0A, 8'h05, 1, {8'h33, 40'h0}, 1'b1};
        vecs[10] = '{8'h0B, 8'h05, 1, {8'h00, 40'h0}, 1'b1};
        vecs[11] = '{8'h0B, 8'h0E, 6, {8'h83, XH, 8'h23, 8'h01, 8'hAB, ZH}, 1'b1};
        vecs[12] = '{8'h03, 8'h00, 2, {8'h55, 8'h66, 32'h0}, 1'b1};
        vecs[13] = '{8'h0A, 8'h2D, 1, {8'h00, 40'h0}, 1'b0};

        // Reset state
        wait_clk(3);
        check("rst miso", 64'(miso), 64'h0);
        check("rst wr_strobe", 64'(wr_strobe), 64'h0);
        check("rst wr_addr", 64'(wr_addr), 64'h0);
        check("rst wr_data", 64'(wr_data), 64'h0);
        check("rst measure_on", 64'(measure_on), 64'h0);
        check("rst busy", 64'(busy), 64'h0);
        check("rst state", 64'(dbg_state), 64'h0);
        rst = 1'b0;
        wait_clk(10);
        pulse_load(12'hF83, 12'h123, 12'h9AB);
        wait_clk(4);

        for (int v = 0; v < 14; v++) run_vec(v, vecs[v]);

        // Snapshot coherence: new sample mid-burst must not appear in this burst
        cs_start();
        spi_bits(8'h0B, 8, rx);
        spi_bits(8'h0E, 8, rx);
        spi_bits(8'h00, 8, rx); check("coh x_lo", 64'(rx), 64'h83);
        spi_bits(8'h00, 8, rx); check("coh x_hi", 64'(rx), 64'(XH));
        pulse_load(12'h456, 12'h789, 12'hABC);
        spi_bits(8'h00, 8, rx); check("coh y_lo", 64'(rx), 64'h23);
        spi_bits(8'h00, 8, rx); check("coh y_hi", 64'(rx), 64'h01);
        spi_bits(8'h00, 8, rx); check("coh z_lo", 64'(rx), 64'hAB);
        spi_bits(8'h00, 8, rx); check("coh z_hi", 64'(rx), 64'(ZH));
        cs_stop();
        hv = '{8'h0B, 8'h0E, 2, {8'h56, 8'h04, 32'h0}, 1'b0};
        run_vec(100, hv);

        // Aborted byte: 4 bits of write data then CS rises
        act_q.delete();
        cs_start();
        spi_bits(8'h0A, 8, rx);
        spi_bits(8'h2F, 8, rx);
        spi_bits(8'hF0, 4, rx);
        cs_stop();
        check("abort strobes", 64'(act_q.size()), 64'h0);
        hv = '{8'h0B, 8'h2F, 1, {8'h00, 40'h0}, 1'b0};
        run_vec(101, hv);

        // Reset in the middle of a read burst
        hv = '{8'h0A, 8'h2D, 1, {8'h02, 40'h0}, 1'b1};
        run_vec(102, hv);
        hv = '{8'h0A, 8'h21, 1, {8'h3C, 40'h0}, 1'b1};
        run_vec(103, hv);
        cs_start();
        spi_bits(8'h0B, 8, rx);
        spi_bits(8'h00, 8, rx);
        spi_bits(8'h00, 2, rx);
        wait_clk(6);
        check("pre-rst miso", 64'(miso), 64'h1);
        check("pre-rst busy", 64'(busy), 64'h1);
        rst = 1'b1;
        wait_clk(1);
        check("midrst miso", 64'(miso), 64'h0);
        check("midrst wr_strobe", 64'(wr_strobe), 64'h0);
        check("midrst wr_addr", 64'(wr_addr), 64'h0);
        check("midrst wr_data", 64'(wr_data), 64'h0);
        check("midrst measure_on", 64'(measure_on), 64'h0);
        check("midrst busy", 64'(busy), 64'h0);
        check("midrst state", 64'(dbg_state), 64'h0);
        wait_clk(2);
        rst = 1'b0;
        wait_clk(10);
        // CS still low from before reset: this traffic must be ignored
        act_q.delete();
        spi_bits(8'h0A, 8, rx);
        spi_bits(8'h21, 8, rx);
        spi_bits(8'h77, 8, rx);
        check("stale-cs strobes", 64'(act_q.size()), 64'h0);
        check("stale-cs state", 64'(dbg_state), 64'h0);
        cs_stop();
        hv = '{8'h0B, 8'h21, 1, {8'h00, 40'h0}, 1'b0};
        run_vec(104, hv);
        hv = '{8'h0B, 8'h0E, 2, {8'h00, 8'h00, 32'h0}, 1'b0};
        run_vec(105, hv);
        hv = '{8'h0B, 8'h00, 1, {8'hAD, 40'h0}, 1'b0};
        run_vec(106, hv);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
